// File: rtl/display_scan_if.sv
// Digit-source / segment-bus bundle for the shared 4-digit 7-segment display.
// master = scan controller (drives columns/segments), slave = sources and display side.
interface display_scan_if;
  logic       enable;
  logic [3:0] dezenas_duzias;
  logic [3:0] unidades_duzias;
  logic [3:0] dezenas_bandeja;
  logic [3:0] unidades_bandeja;
  logic [3:0] display_colune;
  logic [6:0] display_data;
  logic       frame_tick;

  modport master (
    input  enable, dezenas_duzias, unidades_duzias, dezenas_bandeja, unidades_bandeja,
    output display_colune, display_data, frame_tick
  );

  modport slave (
    output enable, dezenas_duzias, unidades_duzias, dezenas_bandeja, unidades_bandeja,
    input  display_colune, display_data, frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of four BCD digits onto one segment bus, with a blank gap
// between digits and a per-frame snapshot. Optional macro DISPLAY_LZS_EN blanks tens zeros.
module display_scan_ctrl #(
  parameter int DWELL = 1000,
  parameter int BLANK = 50
) (
  input  logic           clk,
  input  logic           reset,
  display_scan_if.master bus
);

  localparam int MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0][3:0]  snap_q, snap_d;
  logic [3:0]       colune_q, colune_d;
  logic [6:0]       data_q, data_d;
  logic             tick_q, tick_d;

  logic [3:0][3:0]  live;
  logic             go_show;
  logic             new_frame;
  logic [3:0]       shown_val;

  assign live = {bus.unidades_bandeja, bus.dezenas_bandeja,
                 bus.unidades_duzias, bus.dezenas_duzias};

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  // Column and segments are always computed together so a column never shows stale data.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + 1'b1;
    snap_d    = snap_q;
    colune_d  = colune_q;
    data_d    = data_q;
    tick_d    = 1'b0;
    go_show   = 1'b0;
    new_frame = 1'b0;
    shown_val = '0;

    if (!bus.enable) begin
      state_d  = IDLE;
      idx_d    = '0;
      cnt_d    = '0;
      colune_d = '0;
      data_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          go_show   = 1'b1;
          new_frame = 1'b1;
        end
        SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            if (BLANK > 0) begin
              state_d  = GAP;
              cnt_d    = '0;
              colune_d = '0;
              data_d   = '0;
            end else begin
              go_show   = 1'b1;
              new_frame = (idx_q == 2'd3);
            end
          end
        end
        GAP: begin
          if (cnt_q == BLANK_LAST) begin
            go_show   = 1'b1;
            new_frame = (idx_q == 2'd3);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      if (go_show) begin
        state_d   = SHOW;
        cnt_d     = '0;
        idx_d     = new_frame ? 2'd0 : idx_q + 2'd1;
        tick_d    = new_frame;
        if (new_frame) begin
          snap_d = live;
        end
        shown_val = snap_d[idx_d];
        colune_d  = 4'b1000 >> idx_d;
        data_d    = seg_of(shown_val);
`ifdef DISPLAY_LZS_EN
        if (shown_val == 4'd0 && !idx_d[0]) begin
          data_d = '0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      snap_q   <= '0;
      colune_q <= '0;
      data_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      colune_q <= colune_d;
      data_q   <= data_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.display_colune = colune_q;
  assign bus.display_data   = data_q;
  assign bus.frame_tick     = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: one instance with a blank gap, one without, checked
// against a frame-position model every cycle plus directed literal expectations.
`timescale 1ns/1ps
module tb_display_scan_ctrl;

  localparam int DW   = 4;
  localparam int BL_A = 2;
  localparam int BL_B = 0;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
    7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001
  };

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] din [4];
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         failures = 0;

  display_scan_if bus_a ();
  display_scan_if bus_b ();

  assign bus_a.enable           = enable;
  assign bus_a.dezenas_duzias   = din[0];
  assign bus_a.unidades_duzias  = din[1];
  assign bus_a.dezenas_bandeja  = din[2];
  assign bus_a.unidades_bandeja = din[3];
  assign bus_b.enable           = enable;
  assign bus_b.dezenas_duzias   = din[0];
  assign bus_b.unidades_duzias  = din[1];
  assign bus_b.dezenas_bandeja  = din[2];
  assign bus_b.unidades_bandeja = din[3];

  display_scan_ctrl #(.DWELL(DW), .BLANK(BL_A)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  display_scan_ctrl #(.DWELL(DW), .BLANK(BL_B)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // Model: cycles elapsed since the display was switched on, plus the frame snapshot.
  bit         act  [2];
  int         tcnt [2];
  logic [3:0] snap [2][4];

  function automatic int blank_len(input int i);
    return (i == 0) ? BL_A : BL_B;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset || !enable) begin
      for (int i = 0; i < 2; i++) act[i] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!act[i]) begin
          act[i]  = 1'b1;
          tcnt[i] = 0;
        end else begin
          tcnt[i] = tcnt[i] + 1;
        end
        if (tcnt[i] % (4 * (DW + blank_len(i))) == 0) begin
          for (int j = 0; j < 4; j++) snap[i][j] = din[j];
        end
      end
    end
  end

  function automatic logic [11:0] model_out(input int i);
    logic [3:0] c = '0;
    logic [6:0] d = '0;
    logic       tk = 1'b0;
    int slot, pos, dig;
    if (act[i]) begin
      slot = DW + blank_len(i);
      pos  = tcnt[i] % (4 * slot);
      dig  = pos / slot;
      tk   = (pos == 0);
      if (pos % slot < DW) begin
        c = 4'b1000 >> dig;
        d = SEG_TAB[snap[i][dig]];
`ifdef DISPLAY_LZS_EN
        if (snap[i][dig] == 4'd0 && (dig == 0 || dig == 2)) d = '0;
`endif
      end
    end
    return {c, d, tk};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic [11:0] exp_v, got_v;
      exp_v = model_out(0);
      got_v = {bus_a.display_colune, bus_a.display_data, bus_a.frame_tick};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL model_a t=%0t got col=%b data=%b tick=%b exp col=%b data=%b tick=%b",
                 $time, got_v[11:8], got_v[7:1], got_v[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
      end
      exp_v = model_out(1);
      got_v = {bus_b.display_colune, bus_b.display_data, bus_b.frame_tick};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL model_b t=%0t got col=%b data=%b tick=%b exp col=%b data=%b tick=%b",
                 $time, got_v[11:8], got_v[7:1], got_v[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] d3, input logic en);
    din[0] = d0;
    din[1] = d1;
    din[2] = d2;
    din[3] = d3;
    enable = en;
  endtask

  task automatic checkOutput(input string name, input int inst, input logic [3:0] col,
                             input logic [6:0] data, input logic tick);
    logic [3:0] gc;
    logic [6:0] gd;
    logic       gt;
    if (inst == 0) begin
      gc = bus_a.display_colune; gd = bus_a.display_data; gt = bus_a.frame_tick;
    end else begin
      gc = bus_b.display_colune; gd = bus_b.display_data; gt = bus_b.frame_tick;
    end
    checks++;
    if (gc !== col || gd !== data || gt !== tick) begin
      failures++;
      $display("[TB] FAIL %s t=%0t got col=%b data=%b tick=%b exp col=%b data=%b tick=%b",
               name, $time, gc, gd, gt, col, data, tick);
    end
  endtask

  logic [6:0] zero_digit0;

  initial begin
`ifdef DISPLAY_LZS_EN
    zero_digit0 = 7'b0000000;
`else
    zero_digit0 = 7'b1111110;
`endif
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    #2 reset = 1'b0;
    mon_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("reset_dark", 0, 4'b0000, 7'b0000000, 1'b0);
    end
    enable = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    checkOutput("idle_dark", 0, 4'b0000, 7'b0000000, 1'b0);
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);

    for (int cyc = 0; cyc < 180; cyc++) begin
      @(negedge clk);
      case (cyc)
        0: begin
          checkOutput("a_first_digit0", 0, 4'b1000, 7'b0110000, 1'b1);
          checkOutput("b_first_digit0", 1, 4'b1000, 7'b0110000, 1'b1);
        end
        3:  checkOutput("a_digit0_last", 0, 4'b1000, 7'b0110000, 1'b0);
        4: begin
          checkOutput("a_gap_start", 0, 4'b0000, 7'b0000000, 1'b0);
          checkOutput("b_no_gap_digit1", 1, 4'b0100, 7'b1101101, 1'b0);
        end
        5:  checkOutput("a_gap_end", 0, 4'b0000, 7'b0000000, 1'b0);
        6:  checkOutput("a_digit1", 0, 4'b0100, 7'b1101101, 1'b0);
        12: begin
          checkOutput("a_digit2", 0, 4'b0010, 7'b1111001, 1'b0);
          checkOutput("b_digit3", 1, 4'b0001, 7'b0110011, 1'b0);
        end
        16: checkOutput("b_frame2_tick", 1, 4'b1000, 7'b0110000, 1'b1);
        18: checkOutput("a_digit3", 0, 4'b0001, 7'b0110011, 1'b0);
        23: checkOutput("a_last_gap", 0, 4'b0000, 7'b0000000, 1'b0);
        24: checkOutput("a_frame2_tick", 0, 4'b1000, 7'b0110000, 1'b1);
        32: din[3] = 4'd7;
        42: checkOutput("a_digit3_old_snap", 0, 4'b0001, 7'b0110011, 1'b0);
        60: checkOutput("b_digit3_new_snap", 1, 4'b0001, 7'b1110000, 1'b0);
        66: checkOutput("a_digit3_new_snap", 0, 4'b0001, 7'b1110000, 1'b0);
        85: begin
          checkOutput("a_digit2_before_off", 0, 4'b0010, 7'b1111001, 1'b0);
          enable = 1'b0;
        end
        86: begin
          checkOutput("a_disable_dark", 0, 4'b0000, 7'b0000000, 1'b0);
          checkOutput("b_disable_dark", 1, 4'b0000, 7'b0000000, 1'b0);
          applyStimulus(4'd0, 4'd5, 4'hC, 4'd9, 1'b0);
        end
        87: enable = 1'b1;
        88: begin
          checkOutput("a_restart_digit0", 0, 4'b1000, zero_digit0, 1'b1);
          checkOutput("b_restart_digit0", 1, 4'b1000, zero_digit0, 1'b1);
        end
        94:  checkOutput("a_digit1_five", 0, 4'b0100, 7'b1011011, 1'b0);
        96:  checkOutput("b_digit2_dash", 1, 4'b0010, 7'b0000001, 1'b0);
        100: checkOutput("a_digit2_dash", 0, 4'b0010, 7'b0000001, 1'b0);
        106: checkOutput("a_digit3_nine", 0, 4'b0001, 7'b1111011, 1'b0);
        110: begin
          #3 reset = 1'b0;
          #1 checkOutput("a_async_reset", 0, 4'b0000, 7'b0000000, 1'b0);
          checkOutput("b_async_reset", 1, 4'b0000, 7'b0000000, 1'b0);
        end
        111: reset = 1'b1;
        default: begin
          if (cyc > 112 && cyc % 7 == 0) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          (cyc % 49) != 0);
          end
        end
      endcase
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
